// File: rtl/axil_wb_bridge_v2.sv
// axil_wb_bridge_v2: AXI4-Lite slave to Wishbone classic master bridge with fair read/write arbitration.
// Defining WB_TIMEOUT_EN adds a wait-cycle limit that terminates a stalled Wishbone cycle with SLVERR.
module axil_wb_bridge_v2 #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [AW-1:0]               i_awaddr,
    input  logic                        i_awvalid,
    output logic                        o_awready,
    input  logic [DW-1:0]               i_wdata,
    input  logic [DW/8-1:0]             i_wstrb,
    input  logic                        i_wvalid,
    output logic                        o_wready,
    output logic [1:0]                  o_bresp,
    output logic                        o_bvalid,
    input  logic                        i_bready,
    input  logic [AW-1:0]               i_araddr,
    input  logic                        i_arvalid,
    output logic                        o_arready,
    output logic [DW-1:0]               o_rdata,
    output logic [1:0]                  o_rresp,
    output logic                        o_rvalid,
    input  logic                        i_rready,
    output logic [AW-$clog2(DW/8)-1:0]  o_mwb_adr,
    output logic [DW-1:0]               o_mwb_dat,
    output logic [DW/8-1:0]             o_mwb_sel,
    output logic                        o_mwb_we,
    output logic                        o_mwb_cyc,
    output logic                        o_mwb_stb,
    input  logic [DW-1:0]               i_mwb_rdt,
    input  logic                        i_mwb_ack,
    input  logic                        i_mwb_err
);
    localparam int LSB = $clog2(DW / 8);
    localparam int SW  = DW / 8;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB_WR  = 3'd1;
    localparam logic [2:0] S_WB_RD  = 3'd2;
    localparam logic [2:0] S_B_RESP = 3'd3;
    localparam logic [2:0] S_R_RESP = 3'd4;

    logic [2:0]        r_state;
    logic              r_aw_full, r_w_full, r_ar_full, r_last_rd;
    logic [AW-LSB-1:0] r_awadr, r_aradr;
    logic [DW-1:0]     r_wdata;
    logic [SW-1:0]     r_wstrb;
    logic              r_awready, r_wready, r_arready;
    logic              r_bvalid, r_rvalid;
    logic [1:0]        r_bresp, r_rresp;
    logic [DW-1:0]     r_rdata;
    logic [AW-LSB-1:0] r_adr;
    logic [DW-1:0]     r_dat;
    logic [SW-1:0]     r_sel;
    logic              r_we, r_cyc, r_stb;
    logic              w_wr_ok, w_to, w_term, w_fail, w_unused;

    assign w_wr_ok  = r_aw_full & r_w_full;
    assign w_term   = r_stb & (i_mwb_ack | i_mwb_err | w_to);
    assign w_fail   = i_mwb_err | w_to;
    assign w_unused = ^{i_awaddr[LSB-1:0], i_araddr[LSB-1:0], TIMEOUT > 0};

`ifdef WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;
    assign w_to = r_stb & ~i_mwb_ack & ~i_mwb_err & (r_to_cnt == TW'(TIMEOUT - 1));
    always_ff @(posedge i_clk) begin
        if (i_rst || w_term)
            r_to_cnt <= '0;
        else if (r_stb && !i_mwb_ack && !i_mwb_err)
            r_to_cnt <= r_to_cnt + 1'b1;
    end
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_ar_full <= 1'b0;
            r_last_rd <= 1'b1;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
        end else begin
            // Ready pulses last one cycle so each holding register takes exactly one beat
            r_awready <= i_awvalid & ~r_aw_full & ~r_awready;
            r_wready  <= i_wvalid & ~r_w_full & ~r_wready;
            r_arready <= i_arvalid & ~r_ar_full & ~r_arready;
            if (r_awready && i_awvalid) begin
                r_aw_full <= 1'b1;
                r_awadr   <= i_awaddr[AW-1:LSB];
            end
            if (r_wready && i_wvalid) begin
                r_w_full <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end
            if (r_arready && i_arvalid) begin
                r_ar_full <= 1'b1;
                r_aradr   <= i_araddr[AW-1:LSB];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_wr_ok && (!r_ar_full || r_last_rd)) begin
                        r_state   <= S_WB_WR;
                        r_last_rd <= 1'b0;
                        r_cyc     <= 1'b1;
                        r_stb     <= 1'b1;
                        r_we      <= 1'b1;
                        r_adr     <= r_awadr;
                        r_dat     <= r_wdata;
                        r_sel     <= r_wstrb;
                    end else if (r_ar_full) begin
                        r_state   <= S_WB_RD;
                        r_last_rd <= 1'b1;
                        r_cyc     <= 1'b1;
                        r_stb     <= 1'b1;
                        r_we      <= 1'b0;
                        r_adr     <= r_aradr;
                        r_sel     <= '1;
                    end
                end
                S_WB_WR: begin
                    if (w_term) begin
                        r_state   <= S_B_RESP;
                        r_cyc     <= 1'b0;
                        r_stb     <= 1'b0;
                        r_we      <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_fail ? 2'b10 : 2'b00;
                        r_aw_full <= 1'b0;
                        r_w_full  <= 1'b0;
                    end
                end
                S_WB_RD: begin
                    if (w_term) begin
                        r_state   <= S_R_RESP;
                        r_cyc     <= 1'b0;
                        r_stb     <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rresp   <= w_fail ? 2'b10 : 2'b00;
                        r_rdata   <= w_fail ? '0 : i_mwb_rdt;
                        r_ar_full <= 1'b0;
                    end
                end
                S_B_RESP: begin
                    if (i_bready) begin
                        r_state  <= S_IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                S_R_RESP: begin
                    if (i_rready) begin
                        r_state  <= S_IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_arready = r_arready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;
    assign o_rvalid  = r_rvalid;
    assign o_rresp   = r_rresp;
    assign o_rdata   = r_rdata;
    assign o_mwb_adr = r_adr;
    assign o_mwb_dat = r_dat;
    assign o_mwb_sel = r_sel;
    assign o_mwb_we  = r_we;
    assign o_mwb_cyc = r_cyc;
    assign o_mwb_stb = r_stb;
endmodule

// File: tb/tb_axil_wb_bridge_v2.sv
// tb_axil_wb_bridge_v2: scoreboard bench for the AXI-Lite to Wishbone bridge (32-bit and 64-bit instances).
module tb_axil_wb_bridge_v2;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, mwb_dat, mwb_rdt;
    logic [3:0]  wstrb, mwb_sel;
    logic [1:0]  bresp, rresp;
    logic [9:0]  mwb_adr;
    logic        mwb_we, mwb_cyc, mwb_stb, mwb_ack, mwb_err;

    axil_wb_bridge_v2 #(.AW(12), .DW(32), .TIMEOUT(8)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(awready),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_wvalid(wvalid), .o_wready(wready),
        .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(arready),
        .o_rdata(rdata), .o_rresp(rresp), .o_rvalid(rvalid), .i_rready(rready),
        .o_mwb_adr(mwb_adr), .o_mwb_dat(mwb_dat), .o_mwb_sel(mwb_sel), .o_mwb_we(mwb_we),
        .o_mwb_cyc(mwb_cyc), .o_mwb_stb(mwb_stb),
        .i_mwb_rdt(mwb_rdt), .i_mwb_ack(mwb_ack), .i_mwb_err(mwb_err)
    );

    logic [11:0] d_awaddr, d_araddr;
    logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready, d_arvalid, d_arready, d_rvalid, d_rready;
    logic [63:0] d_wdata, d_rdata, d_dat, d_rdt;
    logic [7:0]  d_wstrb, d_sel;
    logic [1:0]  d_bresp, d_rresp;
    logic [8:0]  d_adr;
    logic        d_we, d_cyc, d_stb, d_ack, d_err;
    assign d_ack = d_stb;

    axil_wb_bridge_v2 #(.AW(12), .DW(64), .TIMEOUT(8)) u_dut64 (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_awaddr(d_awaddr), .i_awvalid(d_awvalid), .o_awready(d_awready),
        .i_wdata(d_wdata), .i_wstrb(d_wstrb), .i_wvalid(d_wvalid), .o_wready(d_wready),
        .o_bresp(d_bresp), .o_bvalid(d_bvalid), .i_bready(d_bready),
        .i_araddr(d_araddr), .i_arvalid(d_arvalid), .o_arready(d_arready),
        .o_rdata(d_rdata), .o_rresp(d_rresp), .o_rvalid(d_rvalid), .i_rready(d_rready),
        .o_mwb_adr(d_adr), .o_mwb_dat(d_dat), .o_mwb_sel(d_sel), .o_mwb_we(d_we),
        .o_mwb_cyc(d_cyc), .o_mwb_stb(d_stb),
        .i_mwb_rdt(d_rdt), .i_mwb_ack(d_ack), .i_mwb_err(d_err)
    );

    typedef struct {
        logic [9:0]  adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          len;
        bit          lat;
    } wb_t;
    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;
    typedef struct {
        logic [8:0]  adr;
        logic [7:0]  sel;
        logic [63:0] dat;
    } dwb_t;

    wb_t        qwb[$];
    rsp_t       qb[$], qr[$];
    dwb_t       dq[$];
    logic [1:0] dqb[$];

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;
    always @(posedge i_clk) cyc_no <= cyc_no + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic exp_wb(input logic [9:0] a, input logic we, input logic [3:0] s, input logic [31:0] d,
                          input int len, input bit lat);
        wb_t w;
        w.adr = a; w.we = we; w.sel = s; w.dat = d; w.len = len; w.lat = lat;
        qwb.push_back(w);
    endtask

    task automatic exp_rsp(input bit is_rd, input logic [1:0] resp, input logic [31:0] data);
        rsp_t r;
        r.resp = resp; r.data = data;
        if (is_rd) qr.push_back(r);
        else qb.push_back(r);
    endtask

    // Simple slave: terminates on the (sl_delay+1)-th strobe cycle with ack, err or both
    int   sl_delay = 0;
    int   sl_cnt = 0;
    bit   sl_err = 0;
    bit   sl_both = 0;
    always @(negedge i_clk) begin
        if (mwb_stb === 1'b1) begin
            mwb_ack = (sl_cnt == sl_delay) && (!sl_err || sl_both);
            mwb_err = (sl_cnt == sl_delay) && sl_err;
            sl_cnt++;
        end else begin
            mwb_ack = 1'b0;
            mwb_err = 1'b0;
            sl_cnt = 0;
        end
    end

    int   aw_hs = 0, w_hs = 0, stb_len = 0, exp_len = 0;
    bit   prev_rst = 1, prev_stb = 0, prev_bwait = 0, d_prev_stb = 0;
    logic [1:0] prev_bresp = 2'b00;
    wb_t  e_wb;
    rsp_t e_rsp;
    dwb_t e_d;
    always @(negedge i_clk) begin
        if (awvalid && awready) aw_hs = cyc_no;
        if (wvalid && wready) w_hs = cyc_no;
        if (!i_rst && !prev_rst) begin
            chk("stb_needs_cyc", !mwb_stb || mwb_cyc, 1'b1);
            if (mwb_stb && !prev_stb) begin
                chk("wb_queue", qwb.size() > 0, 1'b1);
                if (qwb.size() > 0) begin
                    e_wb = qwb.pop_front();
                    chk("wb_adr", mwb_adr, e_wb.adr);
                    chk("wb_we", mwb_we, e_wb.we);
                    chk("wb_sel", mwb_sel, e_wb.sel);
                    if (e_wb.we) chk("wb_dat", mwb_dat, e_wb.dat);
                    if (e_wb.lat) chk("stb_latency", cyc_no - (aw_hs > w_hs ? aw_hs : w_hs), 2);
                    exp_len = e_wb.len;
                end
                stb_len = 1;
            end else if (mwb_stb) begin
                stb_len++;
            end else if (prev_stb) begin
                if (exp_len > 0) chk("stb_len", stb_len, exp_len);
                chk("resp_on_drop", bvalid || rvalid, 1'b1);
            end
            if (prev_bwait) begin
                chk("bvalid_hold", bvalid, 1'b1);
                chk("bresp_hold", bresp, prev_bresp);
            end
            if (bvalid && bready) begin
                chk("b_queue", qb.size() > 0, 1'b1);
                if (qb.size() > 0) begin
                    e_rsp = qb.pop_front();
                    chk("bresp", bresp, e_rsp.resp);
                end
            end
            if (rvalid && rready) begin
                chk("r_queue", qr.size() > 0, 1'b1);
                if (qr.size() > 0) begin
                    e_rsp = qr.pop_front();
                    chk("rresp", rresp, e_rsp.resp);
                    chk("rdata", rdata, e_rsp.data);
                end
            end
            if (d_stb && !d_prev_stb) begin
                chk("d_wb_queue", dq.size() > 0, 1'b1);
                if (dq.size() > 0) begin
                    e_d = dq.pop_front();
                    chk("d_wb_adr", d_adr, e_d.adr);
                    chk("d_wb_sel", d_sel, e_d.sel);
                    chk("d_wb_dat", d_dat, e_d.dat);
                    chk("d_wb_we", d_we, 1'b1);
                end
            end
            if (d_bvalid && d_bready) begin
                chk("d_b_queue", dqb.size() > 0, 1'b1);
                if (dqb.size() > 0) chk("d_bresp", d_bresp, dqb.pop_front());
            end
        end
        prev_rst   = i_rst;
        prev_stb   = mwb_stb;
        prev_bwait = bvalid && !bready;
        prev_bresp = bresp;
        d_prev_stb = d_stb;
    end

    task automatic aw_send(input logic [11:0] a);
        int n = 0;
        awaddr = a; awvalid = 1'b1;
        @(negedge i_clk);
        while (!awready && n < 40) begin @(negedge i_clk); n++; end
        chk("aw_handshake", awready, 1'b1);
        tick(1);
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        @(negedge i_clk);
        while (!wready && n < 40) begin @(negedge i_clk); n++; end
        chk("w_handshake", wready, 1'b1);
        tick(1);
        wvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [11:0] a);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        @(negedge i_clk);
        while (!arready && n < 40) begin @(negedge i_clk); n++; end
        chk("ar_handshake", arready, 1'b1);
        tick(1);
        arvalid = 1'b0;
    endtask

    task automatic daw_send(input logic [11:0] a);
        int n = 0;
        d_awaddr = a; d_awvalid = 1'b1;
        @(negedge i_clk);
        while (!d_awready && n < 40) begin @(negedge i_clk); n++; end
        chk("d_aw_handshake", d_awready, 1'b1);
        tick(1);
        d_awvalid = 1'b0;
    endtask

    task automatic dw_send(input logic [63:0] d, input logic [7:0] s);
        int n = 0;
        d_wdata = d; d_wstrb = s; d_wvalid = 1'b1;
        @(negedge i_clk);
        while (!d_wready && n < 40) begin @(negedge i_clk); n++; end
        chk("d_w_handshake", d_wready, 1'b1);
        tick(1);
        d_wvalid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((qwb.size() != 0 || qb.size() != 0 || qr.size() != 0 || mwb_cyc || bvalid || rvalid) && n < 200) begin
            tick(1);
            n++;
        end
        chk({nm, "_drain"}, qwb.size() + qb.size() + qr.size(), 0);
        tick(2);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
                 mwb_adr, mwb_dat, mwb_sel, mwb_we, mwb_cyc, mwb_stb}, '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
        araddr = '0; arvalid = 0; rready = 1; mwb_rdt = '0; mwb_ack = 0; mwb_err = 0;
        d_awaddr = '0; d_awvalid = 0; d_wdata = '0; d_wstrb = '0; d_wvalid = 0; d_bready = 1;
        d_araddr = '0; d_arvalid = 0; d_rready = 1; d_rdt = '0; d_err = 0;
        tick(3);
        @(negedge i_clk);
        chk_all_zero("reset_outputs");
        tick(1);
        i_rst = 0;
        tick(2);

        // Write with AW and W together, slave acks on the 4th strobe cycle
        sl_delay = 3;
        exp_wb(10'h004, 1'b1, 4'hF, 32'hDEADBEEF, 4, 1'b1);
        exp_rsp(1'b0, 2'b00, '0);
        fork
            aw_send(12'h010);
            w_send(32'hDEADBEEF, 4'hF);
        join
        wait_idle("write_together");

        // Read with err, then the same address with ack
        sl_delay = 0; sl_err = 1; mwb_rdt = 32'hCAFEF00D;
        exp_wb(10'h008, 1'b0, 4'hF, '0, 1, 1'b0);
        exp_rsp(1'b1, 2'b10, 32'h0);
        ar_send(12'h020);
        wait_idle("read_err");
        sl_delay = 1; sl_err = 0; mwb_rdt = 32'h12345678;
        exp_wb(10'h008, 1'b0, 4'hF, '0, 2, 1'b0);
        exp_rsp(1'b1, 2'b00, 32'h12345678);
        ar_send(12'h020);
        wait_idle("read_ack");

        // ack and err together: err wins
        sl_delay = 0; sl_err = 1; sl_both = 1; mwb_rdt = 32'h55AA55AA;
        exp_wb(10'h00C, 1'b0, 4'hF, '0, 1, 1'b0);
        exp_rsp(1'b1, 2'b10, 32'h0);
        ar_send(12'h030);
        wait_idle("read_ack_err");

        // Write with err and partial strobe
        sl_delay = 2; sl_both = 0;
        exp_wb(10'h03F, 1'b1, 4'h3, 32'hA5A5A5A5, 3, 1'b0);
        exp_rsp(1'b0, 2'b10, '0);
        fork
            aw_send(12'h0FC);
            w_send(32'hA5A5A5A5, 4'h3);
        join
        wait_idle("write_err");

        // Fresh reset, then simultaneous write+read; second pair arrives during held B response
        i_rst = 1;
        tick(2);
        i_rst = 0;
        tick(2);
        sl_delay = 1; sl_err = 0; mwb_rdt = 32'h0BADCAFE;
        exp_wb(10'h010, 1'b1, 4'hF, 32'h11111111, 2, 1'b0);
        exp_wb(10'h011, 1'b0, 4'hF, '0, 2, 1'b0);
        exp_wb(10'h012, 1'b1, 4'hC, 32'h22222222, 2, 1'b0);
        exp_rsp(1'b0, 2'b00, '0);
        exp_rsp(1'b1, 2'b00, 32'h0BADCAFE);
        exp_rsp(1'b0, 2'b00, '0);
        bready = 0;
        fork
            aw_send(12'h040);
            w_send(32'h11111111, 4'hF);
            ar_send(12'h044);
        join
        n = 0;
        while (!bvalid && n < 30) begin tick(1); n++; end
        chk("arb_bvalid_seen", bvalid, 1'b1);
        fork
            aw_send(12'h048);
            w_send(32'h22222222, 4'hC);
        join
        tick(8);
        bready = 1;
        wait_idle("arbitration");

        // Slave that does not answer
`ifdef WB_TIMEOUT_EN
        sl_delay = 1000;
        exp_wb(10'h020, 1'b1, 4'hF, 32'h33333333, 8, 1'b0);
        exp_rsp(1'b0, 2'b10, '0);
`else
        sl_delay = 20;
        exp_wb(10'h020, 1'b1, 4'hF, 32'h33333333, 21, 1'b0);
        exp_rsp(1'b0, 2'b00, '0);
`endif
        fork
            aw_send(12'h080);
            w_send(32'h33333333, 4'hF);
        join
        wait_idle("no_ack");

        // Reset during a stalled read
        sl_delay = 1000;
        exp_wb(10'h014, 1'b0, 4'hF, '0, 0, 1'b0);
        ar_send(12'h050);
        n = 0;
        while (!mwb_stb && n < 20) begin tick(1); n++; end
        chk("rst_read_started", mwb_stb, 1'b1);
        tick(2);
        i_rst = 1;
        tick(1);
        i_rst = 0;
        @(negedge i_clk);
        chk_all_zero("reset_mid_read");
        tick(5);
        chk("no_rvalid_after_reset", rvalid, 1'b0);
        sl_delay = 0; mwb_rdt = 32'h76543210;
        exp_wb(10'h014, 1'b0, 4'hF, '0, 1, 1'b0);
        exp_rsp(1'b1, 2'b00, 32'h76543210);
        ar_send(12'h050);
        wait_idle("read_after_reset");

        // 64-bit instance: W five cycles before AW
        begin
            dwb_t dw;
            dw.adr = 9'h003; dw.sel = 8'h0F; dw.dat = 64'h0123456789ABCDEF;
            dq.push_back(dw);
            dqb.push_back(2'b00);
        end
        dw_send(64'h0123456789ABCDEF, 8'h0F);
        tick(4);
        chk("d_no_stb_before_aw", d_stb, 1'b0);
        daw_send(12'h018);
        n = 0;
        while ((dq.size() != 0 || dqb.size() != 0) && n < 50) begin tick(1); n++; end
        chk("d_drain", dq.size() + dqb.size(), 0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axil_wb_bridge_v2.md
Name: axil_wb_bridge_v2

Overview:
Parametrised AXI4-Lite slave to Wishbone classic master bridge. It is the next-generation replacement for the single-direction AXI2WB path in the combined bridge.
- Adds configurable data width.
- Accepts AW and W independently.
- Arbitrates fairly between reads and writes.
- Propagates Wishbone errors and an optional timeout to BRESP/RRESP.
- Sits between the external AXI-Lite interconnect and the Serving Wishbone bus.

Parameters:
AW, 12, byte-address width on AXI; Wishbone address is AW-1:LSB, where LSB = log2(DW/8).
DW, 32, data width; legal values are 32 or 64.
TIMEOUT, 255, Wishbone wait-cycle limit before SLVERR (used only with the optional feature); must be 1 or more.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high, on the single clock i_clk
i_awaddr  in  AW  write address
i_awvalid  in  1  AW valid
o_awready  out  1  AW ready
i_wdata  in  DW  write data
i_wstrb  in  DW/8  write strobes
i_wvalid  in  1  W valid
o_wready  out  1  W ready
o_bresp  out  2  write response (00 OKAY, 10 SLVERR)
o_bvalid  out  1  B valid
i_bready  in  1  B ready
i_araddr  in  AW  read address
i_arvalid  in  1  AR valid
o_arready  out  1  AR ready
o_rdata  out  DW  read data
o_rresp  out  2  read response
o_rvalid  out  1  R valid
i_rready  in  1  R ready
o_mwb_adr  out  AW-LSB  Wishbone word address
o_mwb_dat  out  DW  Wishbone write data
o_mwb_sel  out  DW/8  Wishbone byte select
o_mwb_we  out  1  Wishbone write enable
o_mwb_cyc  out  1  Wishbone cycle
o_mwb_stb  out  1  Wishbone strobe
i_mwb_rdt  in  DW  Wishbone read data
i_mwb_ack  in  1  Wishbone ack
i_mwb_err  in  1  Wishbone error

Behaviour:
- Reset: every output is 0 (all readys, valids, resp, rdata, and the mwb_* outputs). Holding registers are emptied. Arbitration pointer last_rd=1, so a write wins first. The timeout counter is 0.
- Reset mid-operation aborts immediately:
  - cyc/stb drop in the cycle after i_rst is sampled.
  - A pending B or R response is discarded.
- AW and W holding registers (aw_full, w_full) fill independently. The two channels may arrive in any order or together.
- o_awready is a one-cycle registered pulse, asserted the cycle after i_awvalid is sampled high while aw_full=0. The handshake completes in the pulse cycle and i_awaddr is captured there. o_wready and o_arready follow the same rule (ar_full for AR).
- No new AW/W/AR is accepted while the corresponding holding register is full.
- State machine: IDLE, WB_WR, WB_RD, B_RESP, R_RESP.
- IDLE, write ready only (aw_full & w_full): go to WB_WR.
- IDLE, read ready only (ar_full): go to WB_RD.
- IDLE, both ready in the same cycle: go to WB_WR if last_rd=1, else WB_RD. last_rd updates on each grant.
- WB_WR/WB_RD:
  - cyc=stb=1 from the cycle after the grant.
  - adr comes from the captured address bits AW-1:LSB.
  - For a write, we=1, dat=wdata, sel=wstrb. For a read, we=0 and sel is all ones.
- Termination: ack or err sampled high ends the cycle. cyc, stb and we go to 0 next cycle; at the same time bvalid or rvalid goes to 1.
  - resp=00 on ack; resp=10 on err. If ack and err are high together, err wins.
  - For a read, rdata=i_mwb_rdt is captured on ack; on err rdata=0.
  - The consumed holding registers clear on termination.
- B_RESP/R_RESP: valid and resp/rdata stay stable until the ready handshake. Valid falls the cycle after handshake and the FSM returns to IDLE.
- New AW/W/AR may be accepted into empty holding registers during any state. Grant happens only in IDLE.
- Latency with an immediately-acking slave:
  - stb is asserted 2 cycles after the final AW/W handshake.
  - bvalid is asserted 1 cycle after ack.
- o_mwb_stb is never asserted without o_mwb_cyc.

Optional Feature:
WB_TIMEOUT_EN:
- When defined:
  - A counter increments each cycle that stb=1 and ack=err=0.
  - On reaching TIMEOUT, the cycle is terminated exactly as for err: resp=10, rdata=0, and cyc/stb drop.
  - The counter clears on every termination.
- When undefined: no counter is built, and the bridge waits indefinitely for ack/err.

Test Plan:
- Write, AW and W together: awaddr=0x010, wdata=0xDEADBEEF, wstrb=0xF, slave acks after 3 cycles. Expect adr=0x004, sel=F, we=1; bvalid with bresp=00; stb high exactly 4 cycles.
- W arrives 5 cycles before AW, with a 64-bit build (DW=64), wstrb=0x0F, awaddr=0x018. Expect no stb until AW accepted; then adr=0x003, sel=0x0F.
- Read with slave err: araddr=0x020. Expect rvalid, rresp=10, rdata=0; next read to the same address with ack and rdt=0x12345678 gives rresp=00, rdata=0x12345678.
- Simultaneous complete write and read after reset. Expect the write to be granted first; next simultaneous pair grants the read; i_bready held low 10 cycles keeps bvalid/bresp stable.
- WB_TIMEOUT_EN, TIMEOUT=8, slave never acks. Expect stb for 8 cycles, then drop, then bvalid with bresp=10; without the macro, stb remains high.
- Assert i_rst during WB_RD. Expect all outputs 0 the next cycle, no rvalid, and a fresh read completing normally afterwards.
